// File: rtl/spw_monitor_pkg.sv
// Shared constants for the SpaceWire link-monitor register blocks.
// Covers the register word addresses and the edge-capture mode selectors.
package spw_monitor_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CNT  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/spw_sync_bus.sv
// Multi-flop synchroniser for a status bus that may arrive asynchronously.
// Setting STAGES to 0 turns it into a plain wire.
module spw_sync_bus #(
    parameter int WIDTH  = 14,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_data = i_data;
        end else begin : g_chain
            logic [WIDTH-1:0] r_stage [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < STAGES; k++) begin
                        r_stage[k] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int k = 1; k < STAGES; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign o_data = r_stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/spw_monitor_pio_edge.sv
// Avalon-MM monitor port for the SpaceWire link status bus: edge capture,
// interrupt mask, saturating change counter and registered read-back.
module spw_monitor_pio_edge
    import spw_monitor_pkg::*;
#(
    parameter int WIDTH       = 14,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0]     w_data_s;
    logic [WIDTH-1:0]     w_rise;
    logic [WIDTH-1:0]     w_fall;
    logic [WIDTH-1:0]     w_ev;
    logic [WIDTH-1:0]     w_clr;
    logic                 w_wr;
    logic [31:0]          w_mux;
    logic                 w_unused_wdata;

    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_edge;
    logic [WIDTH-1:0]     r_mask;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_readdata;
    logic                 r_irq;

    spw_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_data (in_port),
        .o_data (w_data_s)
    );

    assign w_wr           = chipselect & ~write_n;
    assign w_rise         = w_data_s & ~r_prev;
    assign w_fall         = ~w_data_s & r_prev;
    assign w_clr          = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    always_comb begin
        if (EDGE_MODE == EDGE_RISE) begin
            w_ev = w_rise;
        end else if (EDGE_MODE == EDGE_FALL) begin
            w_ev = w_fall;
        end else begin
            w_ev = w_rise | w_fall;
        end
    end

    always_comb begin
        w_mux = '0;
        case (address)
            ADDR_DATA: w_mux[WIDTH-1:0]     = w_data_s;
            ADDR_CNT:  w_mux[CNT_WIDTH-1:0] = r_cnt;
            ADDR_MASK: w_mux[WIDTH-1:0]     = r_mask;
            default:   w_mux[WIDTH-1:0]     = r_edge;
        endcase
    end

    // A new event outranks a same-cycle clear; a counter clear outranks a same-cycle change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_data_s;
            r_edge     <= w_ev | (r_edge & ~w_clr);
            r_readdata <= w_mux;
            r_irq      <= |(r_edge & r_mask);
            if (w_wr && address == ADDR_MASK) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr && address == ADDR_CNT) begin
                r_cnt <= '0;
            end else if (w_data_s != r_prev && r_cnt != {CNT_WIDTH{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_spw_monitor_pio_edge.sv
// Directed bench: default instance, a rising-only instance and a 4-bit-counter
// instance share the Avalon bus; each has its own monitored input bus.
module tb_spw_monitor_pio_edge;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [13:0] in0, in1, in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int passes = 0;

    spw_monitor_pio_edge dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    spw_monitor_pio_edge #(.EDGE_MODE(0)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    spw_monitor_pio_edge #(.CNT_WIDTH(4)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in0 = 14'h3FFF; in1 = 14'h3FFF; in2 = 14'h3FFF;
        tick(3);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL reset_readdata: got %h expected %h", rd0, 32'h0); else passes++;
        checks++; if (irq0 !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected %b", irq0, 1'b0); else passes++;
        reset = 1'b0;
        address = 2'd0;
        tick(2);
        rd(2'd0);
        checks++; if (rd0 !== 32'h3FFF) $display("[TB] FAIL data_after_reset: got %h expected %h", rd0, 32'h3FFF); else passes++;
        rd(2'd3);
        checks++; if (rd0 !== 32'h3FFF) $display("[TB] FAIL edge_any_after_reset: got %h expected %h", rd0, 32'h3FFF); else passes++;
        checks++; if (rd1 !== 32'h3FFF) $display("[TB] FAIL edge_rise_after_reset: got %h expected %h", rd1, 32'h3FFF); else passes++;
        rd(2'd1);
        checks++; if (rd0 !== 32'h1) $display("[TB] FAIL cnt_after_reset: got %h expected %h", rd0, 32'h1); else passes++;
    endtask

    task automatic test_edge_irq;
        int lat;
        in0 = 14'h3FFB;
        tick(5);
        wr(2'd2, 32'h0000_0004);
        wr(2'd3, 32'hFFFF_FFFF);
        tick(2);
        checks++; if (irq0 !== 1'b0) $display("[TB] FAIL irq_idle: got %b expected %b", irq0, 1'b0); else passes++;
        in0 = 14'h3FFF;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            if (irq0 === 1'b1 && lat == 0) lat = n;
        end
        checks++; if (lat !== 4) $display("[TB] FAIL irq_latency: got %0d expected %0d", lat, 4); else passes++;
        rd(2'd3);
        checks++; if (rd0 !== 32'h4) $display("[TB] FAIL edge_bit2: got %h expected %h", rd0, 32'h4); else passes++;
        wr(2'd3, 32'h0000_0004);
        tick(1);
        checks++; if (irq0 !== 1'b0) $display("[TB] FAIL irq_clear: got %b expected %b", irq0, 1'b0); else passes++;
    endtask

    task automatic test_edge_mode;
        wr(2'd2, 32'h0000_3FFF);
        wr(2'd3, 32'hFFFF_FFFF);
        tick(2);
        in1 = 14'h3FDF;
        tick(6);
        rd(2'd3);
        checks++; if (rd1 !== 32'h0) $display("[TB] FAIL rise_mode_fall_ignored: got %h expected %h", rd1, 32'h0); else passes++;
        checks++; if (irq1 !== 1'b0) $display("[TB] FAIL rise_mode_irq_low: got %b expected %b", irq1, 1'b0); else passes++;
        in1 = 14'h3FFF;
        tick(5);
        rd(2'd3);
        checks++; if (rd1 !== 32'h20) $display("[TB] FAIL rise_mode_bit5: got %h expected %h", rd1, 32'h20); else passes++;
        checks++; if (irq1 !== 1'b1) $display("[TB] FAIL rise_mode_irq_high: got %b expected %b", irq1, 1'b1); else passes++;
    endtask

    task automatic test_collision;
        in0 = 14'h3FFE;
        tick(5);
        wr(2'd3, 32'hFFFF_FFFF);
        in0 = 14'h3FFF;
        tick(2);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3);
        checks++; if (rd0 !== 32'h1) $display("[TB] FAIL set_beats_clear: got %h expected %h", rd0, 32'h1); else passes++;
        wr(2'd3, 32'h0000_0001);
        rd(2'd3);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL w1c_bit0: got %h expected %h", rd0, 32'h0); else passes++;
    endtask

    task automatic test_counter;
        tick(3);
        wr(2'd1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            in0 = in0 ^ 14'h0008; in2 = in2 ^ 14'h0008;
            tick(1);
            in0 = in0 ^ 14'h0008; in2 = in2 ^ 14'h0008;
            tick(1);
        end
        tick(4);
        rd(2'd1);
        checks++; if (rd0 !== 32'd20) $display("[TB] FAIL cnt_20: got %0d expected %0d", rd0, 20); else passes++;
        checks++; if (rd2 !== 32'd15) $display("[TB] FAIL cnt_saturate: got %0d expected %0d", rd2, 15); else passes++;
    endtask

    task automatic test_back_to_back;
        in0 = in0 ^ 14'h0008;
        tick(2);
        wr(2'd1, 32'h0);
        rd(2'd1);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL cnt_clear_wins: got %0d expected %0d", rd0, 0); else passes++;
    endtask

    task automatic test_reset_mid;
        in0 = 14'h0000;
        tick(5);
        wr(2'd1, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) begin
            in0 = in0 ^ 14'h0003;
            tick(2);
        end
        tick(3);
        rd(2'd1);
        checks++; if (rd0 !== 32'd7) $display("[TB] FAIL pre_reset_cnt: got %0d expected %0d", rd0, 7); else passes++;
        rd(2'd3);
        checks++; if (rd0 !== 32'h3) $display("[TB] FAIL pre_reset_edge: got %h expected %h", rd0, 32'h3); else passes++;
        wr(2'd2, 32'h0000_0003);
        tick(2);
        checks++; if (irq0 !== 1'b1) $display("[TB] FAIL pre_reset_irq: got %b expected %b", irq0, 1'b1); else passes++;
        in0 = 14'h0000;
        reset = 1'b1;
        tick(1);
        checks++; if (irq0 !== 1'b0) $display("[TB] FAIL mid_reset_irq: got %b expected %b", irq0, 1'b0); else passes++;
        tick(1);
        reset = 1'b0;
        tick(3);
        rd(2'd3);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL post_reset_edge: got %h expected %h", rd0, 32'h0); else passes++;
        rd(2'd1);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL post_reset_cnt: got %h expected %h", rd0, 32'h0); else passes++;
        rd(2'd2);
        checks++; if (rd0 !== 32'h0) $display("[TB] FAIL post_reset_mask: got %h expected %h", rd0, 32'h0); else passes++;
        checks++; if (irq0 !== 1'b0) $display("[TB] FAIL post_reset_irq: got %b expected %b", irq0, 1'b0); else passes++;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in0 = 14'h3FFF; in1 = 14'h3FFF; in2 = 14'h3FFF;
        test_reset();
        test_edge_irq();
        test_edge_mode();
        test_collision();
        test_counter();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
